sky130_sram_1rw1r_param: RTL and testbench



---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_lane_merge.sv | 23 ++
 rtl/sky130_sram_1rw1r_param.sv | 180 ++++++++++++++++++
 tb/tb_sky130_sram_1rw1r_param.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the parametrised sky130 1RW+1R SRAM model.
package sram_pkg;

   localparam int COLL_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
   } req_t;

   function automatic int num_wmasks(input int data_width, input int wmask_width);
      return data_width / wmask_width;
   endfunction

endpackage

// File: rtl/sram_lane_merge.sv
// Combinational per-lane merge: lanes whose mask bit is set take new_word,
// the rest keep old_word.
module sram_lane_merge #(
   parameter int DATA_WIDTH  = 32,
   parameter int WMASK_WIDTH = 8,
   parameter int NUM_WMASKS  = 4
) (
   input  logic [DATA_WIDTH-1:0] old_word,
   input  logic [DATA_WIDTH-1:0] new_word,
   input  logic [NUM_WMASKS-1:0] mask,
   output logic [DATA_WIDTH-1:0] merged_word
);

   always_comb begin
      merged_word = old_word;
      for (int i = 0; i < NUM_WMASKS; i++) begin
         if (mask[i]) begin
            merged_word[i*WMASK_WIDTH +: WMASK_WIDTH] = new_word[i*WMASK_WIDTH +: WMASK_WIDTH];
         end
      end
   end

endmodule

// File: rtl/sky130_sram_1rw1r_param.sv
// Parametrised single-clock 1RW+1R SRAM model with synchronous output reset,
// collision counter and optional output register. Define SRAM_COLLISION_FWD_EN
// to forward freshly written lanes to a colliding port 1 read.
module sky130_sram_1rw1r_param
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
   parameter int WMASK_WIDTH = 8,
   parameter int OUT_REG     = 0,
   localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_WIDTH)
) (
   input  logic                      clk0,
   input  logic                      rstb0,
   input  logic                      csb0,
   input  logic                      web0,
   input  logic [NUM_WMASKS-1:0]     wmask0,
   input  logic [ADDR_WIDTH-1:0]     addr0,
   input  logic [DATA_WIDTH-1:0]     din0,
   output logic [DATA_WIDTH-1:0]     dout0,
   output logic                      dout0_valid,
   input  logic                      csb1,
   input  logic [ADDR_WIDTH-1:0]     addr1,
   output logic [DATA_WIDTH-1:0]     dout1,
   output logic                      dout1_valid,
   output logic                      collision,
   output logic [COLL_CNT_WIDTH-1:0] coll_count
);

   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = RAM_DEPTH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   req_t                  req0;
   logic                  in_range0;
   logic                  in_range1;
   logic                  wr_en;
   logic                  rd0_en;
   logic                  rd1_en;
   logic                  coll;
   logic                  coll_to_out;
   logic [DATA_WIDTH-1:0] old0;
   logic [DATA_WIDTH-1:0] old1;
   logic [DATA_WIDTH-1:0] wr_word;
   logic [DATA_WIDTH-1:0] fwd_word;
   logic [DATA_WIDTH-1:0] rd1_word;

   logic                  s1_v0;
   logic                  s1_v1;
   logic                  s1_coll;
   logic [DATA_WIDTH-1:0] s1_d0;
   logic [DATA_WIDTH-1:0] s1_d1;

   // A write with an empty mask or an out-of-range address never touches the
   // array, so it can neither write nor collide.
   always_comb begin
      req0 = IDLE;
      if (!csb0) begin
         req0 = web0 ? READ : WRITE;
      end
      in_range0 = {1'b0, addr0} < DEPTH_LIMIT;
      in_range1 = {1'b0, addr1} < DEPTH_LIMIT;
      old0      = in_range0 ? mem[addr0] : '0;
      old1      = in_range1 ? mem[addr1] : '0;
      wr_en     = (req0 == WRITE) && in_range0 && (|wmask0);
      rd0_en    = (req0 == READ);
      rd1_en    = !csb1;
      coll      = wr_en && rd1_en && (addr0 == addr1);
   end

   sram_lane_merge #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WMASK_WIDTH (WMASK_WIDTH),
      .NUM_WMASKS  (NUM_WMASKS)
   ) u_wr_merge (
      .old_word    (old0),
      .new_word    (din0),
      .mask        (wmask0),
      .merged_word (wr_word)
   );

`ifdef SRAM_COLLISION_FWD_EN
   sram_lane_merge #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WMASK_WIDTH (WMASK_WIDTH),
      .NUM_WMASKS  (NUM_WMASKS)
   ) u_fwd_merge (
      .old_word    (old1),
      .new_word    (din0),
      .mask        (wmask0),
      .merged_word (fwd_word)
   );
`else
   assign fwd_word = old1;
`endif

   assign rd1_word = coll ? fwd_word : old1;

   always_ff @(posedge clk0) begin
      if (rstb0 && wr_en) begin
         mem[addr0] <= wr_word;
      end
   end

   // Data registers only load on a valid beat so an idle port holds its value.
   always_ff @(posedge clk0) begin
      if (!rstb0) begin
         s1_v0   <= 1'b0;
         s1_v1   <= 1'b0;
         s1_coll <= 1'b0;
         s1_d0   <= '0;
         s1_d1   <= '0;
      end else begin
         s1_v0   <= rd0_en;
         s1_v1   <= rd1_en;
         s1_coll <= coll;
         if (rd0_en) begin
            s1_d0 <= old0;
         end
         if (rd1_en) begin
            s1_d1 <= rd1_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  s2_v0;
         logic                  s2_v1;
         logic                  s2_coll;
         logic [DATA_WIDTH-1:0] s2_d0;
         logic [DATA_WIDTH-1:0] s2_d1;

         always_ff @(posedge clk0) begin
            if (!rstb0) begin
               s2_v0   <= 1'b0;
               s2_v1   <= 1'b0;
               s2_coll <= 1'b0;
               s2_d0   <= '0;
               s2_d1   <= '0;
            end else begin
               s2_v0   <= s1_v0;
               s2_v1   <= s1_v1;
               s2_coll <= s1_coll;
               if (s1_v0) begin
                  s2_d0 <= s1_d0;
               end
               if (s1_v1) begin
                  s2_d1 <= s1_d1;
               end
            end
         end

         assign dout0       = s2_d0;
         assign dout0_valid = s2_v0;
         assign dout1       = s2_d1;
         assign dout1_valid = s2_v1;
         assign collision   = s2_coll;
         assign coll_to_out = s1_coll;
      end else begin : g_no_out_reg
         assign dout0       = s1_d0;
         assign dout0_valid = s1_v0;
         assign dout1       = s1_d1;
         assign dout1_valid = s1_v1;
         assign collision   = s1_coll;
         assign coll_to_out = coll;
      end
   endgenerate

   // The counter steps on the same edge that raises the collision output.
   always_ff @(posedge clk0) begin
      if (!rstb0) begin
         coll_count <= '0;
      end else if (coll_to_out && (coll_count != '1)) begin
         coll_count <= coll_count + COLL_CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Self-checking bench for sky130_sram_1rw1r_param (RAM_DEPTH=1000); honours
// SRAM_COLLISION_FWD_EN so it matches the build it is compiled with.
module tb_sky130_sram_1rw1r_param;

   localparam int OUT_REG = 0;
   localparam int LAT     = OUT_REG + 1;
   localparam int DEPTH   = 1000;
`ifdef SRAM_COLLISION_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      bit          rst_n;
      bit          cs0;
      bit          we0b;
      logic [3:0]  m;
      logic [9:0]  a0;
      logic [31:0] di;
      bit          cs1;
      logic [9:0]  a1;
      bit          e_v0;
      logic [31:0] e_d0;
      bit          e_v1;
      logic [31:0] e_d1;
      bit          e_coll;
      logic [15:0] e_cnt;
   } vec_t;

   typedef struct {
      bit          v0;
      logic [31:0] d0;
      bit          v1;
      logic [31:0] d1;
      bit          coll;
   } beat_t;

   logic        clk0 = 1'b0;
   logic        rstb0;
   logic        csb0;
   logic        web0;
   logic [3:0]  wmask0;
   logic [9:0]  addr0;
   logic [31:0] din0;
   logic [31:0] dout0;
   logic        dout0_valid;
   logic        csb1;
   logic [9:0]  addr1;
   logic [31:0] dout1;
   logic        dout1_valid;
   logic        collision;
   logic [15:0] coll_count;

   logic [31:0] mem_model [DEPTH];
   beat_t       pipe [LAT];
   bit          m_v0, m_v1, m_coll;
   logic [31:0] m_d0, m_d1;
   logic [15:0] m_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk0 = ~clk0;

   sky130_sram_1rw1r_param #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (10),
      .RAM_DEPTH   (DEPTH),
      .WMASK_WIDTH (8),
      .OUT_REG     (OUT_REG)
   ) dut (
      .clk0        (clk0),
      .rstb0       (rstb0),
      .csb0        (csb0),
      .web0        (web0),
      .wmask0      (wmask0),
      .addr0       (addr0),
      .din0        (din0),
      .dout0       (dout0),
      .dout0_valid (dout0_valid),
      .csb1        (csb1),
      .addr1       (addr1),
      .dout1       (dout1),
      .dout1_valid (dout1_valid),
      .collision   (collision),
      .coll_count  (coll_count)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock of stimulus; the model computes each response from the rules
   // and delays it by the read latency before it reaches the outputs.
   task automatic apply_stimulus(input vec_t v, input bit chk_model, input bit chk_tbl);
      beat_t       nb;
      beat_t       arr;
      logic [31:0] wm, old0, old1, merged;
      bit          wr;
      rstb0  = v.rst_n;
      csb0   = v.cs0;
      web0   = v.we0b;
      wmask0 = v.m;
      addr0  = v.a0;
      din0   = v.di;
      csb1   = v.cs1;
      addr1  = v.a1;
      old0   = (int'(v.a0) < DEPTH) ? mem_model[int'(v.a0)] : 32'h0;
      old1   = (int'(v.a1) < DEPTH) ? mem_model[int'(v.a1)] : 32'h0;
      wm     = {{8{v.m[3]}}, {8{v.m[2]}}, {8{v.m[1]}}, {8{v.m[0]}}};
      merged = (old0 & ~wm) | (v.di & wm);
      wr     = !v.cs0 && !v.we0b && (int'(v.a0) < DEPTH) && (v.m != 4'h0);
      nb.v0   = !v.cs0 && v.we0b;
      nb.d0   = old0;
      nb.v1   = !v.cs1;
      nb.coll = wr && nb.v1 && (v.a0 == v.a1);
      nb.d1   = (nb.coll && FWD) ? merged : old1;
      @(posedge clk0);
      if (!v.rst_n) begin
         for (int i = 0; i < LAT; i++) pipe[i] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
         m_v0 = 0; m_v1 = 0; m_coll = 0; m_d0 = 0; m_d1 = 0; m_cnt = 0;
      end else begin
         if (wr) mem_model[int'(v.a0)] = merged;
         for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = nb;
         arr     = pipe[LAT-1];
         m_v0    = arr.v0;
         m_v1    = arr.v1;
         m_coll  = arr.coll;
         if (arr.v0) m_d0 = arr.d0;
         if (arr.v1) m_d1 = arr.d1;
         if (arr.coll && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      #1;
      if (chk_model) begin
         check_output("model dout0", dout0, m_d0);
         check_output("model dout0_valid", {31'h0, dout0_valid}, {31'h0, m_v0});
         check_output("model dout1", dout1, m_d1);
         check_output("model dout1_valid", {31'h0, dout1_valid}, {31'h0, m_v1});
         check_output("model collision", {31'h0, collision}, {31'h0, m_coll});
         check_output("model coll_count", {16'h0, coll_count}, {16'h0, m_cnt});
      end
      if (chk_tbl) begin
         check_output("vec dout0", dout0, v.e_d0);
         check_output("vec dout0_valid", {31'h0, dout0_valid}, {31'h0, v.e_v0});
         check_output("vec dout1", dout1, v.e_d1);
         check_output("vec dout1_valid", {31'h0, dout1_valid}, {31'h0, v.e_v1});
         check_output("vec collision", {31'h0, collision}, {31'h0, v.e_coll});
         check_output("vec coll_count", {16'h0, coll_count}, {16'h0, v.e_cnt});
      end
   endtask

   function automatic vec_t mk(input bit rst_n, input bit cs0, input bit we0b, input logic [3:0] m,
                               input logic [9:0] a0, input logic [31:0] di, input bit cs1,
                               input logic [9:0] a1);
      vec_t v;
      v = '{rst_n, cs0, we0b, m, a0, di, cs1, a1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0};
      return v;
   endfunction

   initial begin
      vec_t        rst_tbl [$];
      vec_t        dir_tbl [$];
      vec_t        v;
      logic [31:0] coll_d1;
      logic [31:0] fill;
      logic [9:0]  ra0;
      int          guard;

      coll_d1 = FWD ? 32'hCAFEF00D : 32'h0;
      rstb0 = 0; csb0 = 1; web0 = 1; wmask0 = 0; addr0 = 0; din0 = 0; csb1 = 1; addr1 = 0;
      m_v0 = 0; m_v1 = 0; m_coll = 0; m_d0 = 0; m_d1 = 0; m_cnt = 0;
      for (int i = 0; i < LAT; i++) pipe[i] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0};

      //          rst cs0 web m     a0    din           cs1 a1    v0 d0            v1 d1            col cnt
      rst_tbl.push_back('{0, 1, 1, 4'h0, 10'd0, 32'h0, 1, 10'd0, 0, 32'h0, 0, 32'h0, 0, 16'd0});
      rst_tbl.push_back('{0, 1, 1, 4'h0, 10'd0, 32'h0, 0, 10'd3, 0, 32'h0, 0, 32'h0, 0, 16'd0});
      rst_tbl.push_back('{1, 1, 1, 4'h0, 10'd0, 32'h0, 1, 10'd0, 0, 32'h0, 0, 32'h0, 0, 16'd0});
      foreach (rst_tbl[i]) apply_stimulus(rst_tbl[i], 1'b1, 1'b1);

      for (int i = 0; i < DEPTH; i++) begin
         fill = (i == 5) ? 32'h11223344 : (i == 7) ? 32'h0 : $urandom;
         apply_stimulus(mk(1, 0, 0, 4'hF, 10'(i), fill, 1, 10'd0), 1'b1, 1'b0);
      end

      dir_tbl.push_back('{1, 0, 0, 4'b0101, 10'd5, 32'hDEADBEEF, 1, 10'd0, 0, 32'h0, 0, 32'h0, 0, 16'd0});
      dir_tbl.push_back('{1, 0, 1, 4'h0, 10'd5, 32'h0, 1, 10'd0, 1, 32'h11AD33EF, 0, 32'h0, 0, 16'd0});
      dir_tbl.push_back('{1, 0, 0, 4'hF, 10'd7, 32'hCAFEF00D, 0, 10'd7, 0, 32'h11AD33EF, 1, coll_d1, 1, 16'd1});
      dir_tbl.push_back('{1, 1, 1, 4'h0, 10'd0, 32'h0, 1, 10'd0, 0, 32'h11AD33EF, 0, coll_d1, 0, 16'd1});
      dir_tbl.push_back('{1, 1, 1, 4'h0, 10'd0, 32'h0, 0, 10'd7, 0, 32'h11AD33EF, 1, 32'hCAFEF00D, 0, 16'd1});
      dir_tbl.push_back('{1, 0, 0, 4'hF, 10'd1010, 32'h12345678, 1, 10'd0, 0, 32'h11AD33EF, 0, 32'hCAFEF00D, 0, 16'd1});
      dir_tbl.push_back('{1, 0, 1, 4'h0, 10'd1010, 32'h0, 0, 10'd1010, 1, 32'h0, 1, 32'h0, 0, 16'd1});
      dir_tbl.push_back('{1, 0, 0, 4'hF, 10'd1010, 32'hAAAAAAAA, 0, 10'd1010, 0, 32'h0, 1, 32'h0, 0, 16'd1});
      dir_tbl.push_back('{1, 0, 0, 4'h0, 10'd5, 32'hFFFFFFFF, 0, 10'd5, 0, 32'h0, 1, 32'h11AD33EF, 0, 16'd1});
      dir_tbl.push_back('{1, 0, 1, 4'h0, 10'd5, 32'h0, 1, 10'd0, 1, 32'h11AD33EF, 0, 32'h11AD33EF, 0, 16'd1});
      dir_tbl.push_back('{1, 0, 1, 4'h0, 10'd5, 32'h0, 0, 10'd7, 1, 32'h11AD33EF, 1, 32'hCAFEF00D, 0, 16'd1});
      foreach (dir_tbl[i]) apply_stimulus(dir_tbl[i], 1'b1, 1'b1);

      // Random traffic with port 1 often aimed at port 0's address; a reset
      // pulse in the middle must drop everything in flight.
      for (int i = 0; i < 1000; i++) begin
         ra0 = 10'($urandom_range(0, 1023));
         v = mk((i < 500 || i > 501), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                4'($urandom), ra0, $urandom, $urandom_range(0, 3) == 0,
                ($urandom_range(0, 3) == 0) ? ra0 : 10'($urandom_range(0, 1023)));
         apply_stimulus(v, 1'b1, 1'b0);
      end

      apply_stimulus(mk(1, 0, 1, 4'h0, 10'd5, 32'h0, 0, 10'd7), 1'b1, 1'b0);
      v = '{0, 0, 1, 4'h0, 10'd5, 32'h0, 0, 10'd7, 0, 32'h0, 0, 32'h0, 0, 16'd0};
      apply_stimulus(v, 1'b1, 1'b1);
      apply_stimulus(mk(1, 1, 1, 4'h0, 10'd0, 32'h0, 1, 10'd0), 1'b1, 1'b0);

      guard = 0;
      while (m_cnt != 16'hFFFE && guard < 70000) begin
         apply_stimulus(mk(1, 0, 0, 4'hF, 10'd9, $urandom, 0, 10'd9), 1'b0, 1'b0);
         guard++;
      end
      check_output("coll_count reaches FFFE", {16'h0, coll_count}, 32'h0000FFFE);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(mk(1, 0, 0, 4'hF, 10'd9, $urandom, 0, 10'd9), 1'b1, 1'b0);
         check_output("coll_count saturates", {16'h0, coll_count}, 32'h0000FFFF);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
